// File: rtl/unpack_pkg.sv
// Shared lane helpers for the pack/unpack datapath blocks.
// Counting and unary-mask utilities sized for up to 64 lanes.
package unpack_pkg;

  localparam int MAX_LANES = 64;

  typedef logic [6:0] lane_cnt_t;
  typedef logic [5:0] lane_idx_t;

  function automatic lane_cnt_t popcnt(
    input logic [MAX_LANES-1:0] v
  );
    lane_cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++)
      c = c + lane_cnt_t'(v[i]);
    return c;
  endfunction

  // n = 64 wraps the shift to zero, giving all ones
  function automatic logic [MAX_LANES-1:0] to_unary(
    input lane_cnt_t n
  );
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/unpack_xbar.sv
// Scatter crossbar: oldest entries fan out to the set mask lanes.
// Unselected lanes are driven to zero.
module unpack_xbar
  import unpack_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic [N-1:0][W-1:0] ent,
  input  logic [N-1:0]        mask,
  output logic [N-1:0][W-1:0] lanes
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  lane_idx_t cnt;

  always_comb begin
    cnt   = '0;
    lanes = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        lanes[i] = ent[cnt[LW-1:0]];
        cnt      = cnt + lane_idx_t'(1);
      end
    end
  end

endmodule

// File: rtl/unpack.sv
// Residue-buffered unpacker: packed beats in, masked scatter out.
// Holds up to 2N entries so a full request can follow a short beat.
module unpack
  import unpack_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [N-1:0][W-1:0] in_w,
  input  logic [N-1:0]        in_vld_w,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [N-1:0]        req_mask,
  output logic                out_vld_r,
  output logic [N-1:0][W-1:0] out_r,
  output logic [N-1:0]        out_mask_r
);

  localparam int OW = $clog2(2*N+1);
  localparam int BW = $clog2(2*N);
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [OW-1:0] occ_r;
  logic [OW-1:0] occ_nxt;
  logic [OW-1:0] pc_req;
  logic [OW-1:0] pc_in;
  logic [OW-1:0] cons;
  logic [OW-1:0] add;
  logic [OW-1:0] rem;

  logic [W-1:0] buf_r   [2*N];
  logic [W-1:0] buf_nxt [2*N];

  logic [N-1:0][W-1:0] head;
  logic [N-1:0][W-1:0] lanes;

  logic req_acc;
  logic in_acc;

  assign pc_req = OW'(popcnt(MAX_LANES'(req_mask)));
  assign pc_in  = OW'(popcnt(MAX_LANES'(in_vld_w)));

  // Readiness during reset assumes the buffer is already empty
  assign in_rdy  = rst | (occ_r <= OW'(N));
  assign req_rdy = rst ? (req_mask == '0)
                       : (occ_r >= pc_req);

  assign req_acc = req_vld & req_rdy & ~rst;
  assign in_acc  = in_vld & in_rdy & ~rst;

  assign cons    = req_acc ? pc_req : '0;
  assign add     = in_acc ? pc_in : '0;
  assign rem     = occ_r - cons;
  assign occ_nxt = rem + add;

  always_comb begin
    int r;
    int c;
    int a;
    r = int'(rem);
    c = int'(cons);
    a = int'(add);
    for (int j = 0; j < 2*N; j++) begin
      buf_nxt[j] = buf_r[j];
      if (j < r)
        buf_nxt[j] = buf_r[BW'(j + c)];
      else if (j - r < a)
        buf_nxt[j] = in_w[LW'(j - r)];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      head[i] = buf_r[i];
  end

  unpack_xbar #(
    .N (N),
    .W (W)
  ) u_xbar (
    .ent   (head),
    .mask  (req_mask),
    .lanes (lanes)
  );

  always_ff @(posedge clk) begin
    if (rst)
      occ_r <= '0;
    else
      occ_r <= occ_nxt;
  end

  always_ff @(posedge clk) begin
    buf_r <= buf_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_mask_r <= '0;
    end else begin
      out_vld_r <= req_acc;
      if (req_acc)
        out_mask_r <= req_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc)
      out_r <= lanes;
  end

  a_occ_max: assert property (
    @(posedge clk) disable iff (rst)
    occ_r <= OW'(2*N)
  );

  a_unary: assert property (
    @(posedge clk) disable iff (rst)
    in_acc |-> (in_vld_w ==
      N'(to_unary(popcnt(MAX_LANES'(in_vld_w)))))
  );

endmodule

// File: tb/tb_unpack.sv
// Table-driven bench for unpack with a queue-based reference model.
// Expected scatter results are queued at acceptance, checked a cycle later.
module tb_unpack;

  localparam int N = 8;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_vld;
  logic                in_rdy;
  logic [N-1:0][W-1:0] in_w;
  logic [N-1:0]        in_vld_w;
  logic                req_vld;
  logic                req_rdy;
  logic [N-1:0]        req_mask;
  logic                out_vld_r;
  logic [N-1:0][W-1:0] out_r;
  logic [N-1:0]        out_mask_r;

  always #5 clk = ~clk;

  unpack #(
    .N (N),
    .W (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_w       (in_w),
    .in_vld_w   (in_vld_w),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_mask   (req_mask),
    .out_vld_r  (out_vld_r),
    .out_r      (out_r),
    .out_mask_r (out_mask_r)
  );

  typedef struct {
    int r;
    int iv;
    int n;
    int rv;
    int m;
    int e_ir;
    int e_rr;
    int e_occ;
  } vec_t;

  vec_t tv[22];

  int nvec = 0;
  int nerr = 0;
  int seq  = 0;

  logic [W-1:0]   mq[$];
  logic [N*W-1:0] eq_d[$];
  logic [N-1:0]   eq_m[$];
  logic           pend;
  logic [N*W-1:0] last_d;
  logic [N-1:0]   last_m;
  bit             known = 0;

  task automatic chk(input string nm,
                     input logic [N*W-1:0] a,
                     input logic [N*W-1:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic step(input vec_t v);
    logic [N*W-1:0] d;
    @(negedge clk);
    rst      = v.r[0];
    in_vld   = v.iv[0];
    in_vld_w = '0;
    in_w     = '0;
    for (int i = 0; i < v.n; i++) begin
      in_vld_w[i] = 1'b1;
      in_w[i]     = 32'hA500_0000 + 32'(seq + i);
    end
    req_vld  = v.rv[0];
    req_mask = 8'(v.m);
    #1;
    chk("in_rdy", in_rdy, v.e_ir);
    chk("req_rdy", req_rdy, v.e_rr);
    pend = 1'b0;
    if (v.r != 0) begin
      mq.delete();
      last_m = '0;
    end else begin
      if (v.rv != 0 && v.e_rr != 0) begin
        d = '0;
        for (int i = 0; i < N; i++)
          if (v.m[i])
            d[i*W +: W] = mq.pop_front();
        eq_d.push_back(d);
        eq_m.push_back(8'(v.m));
        pend = 1'b1;
      end
      if (v.iv != 0 && v.e_ir != 0) begin
        for (int i = 0; i < v.n; i++)
          mq.push_back(in_w[i]);
        seq = seq + v.n;
      end
    end
    @(posedge clk);
    #1;
    chk("occ", dut.occ_r, v.e_occ);
    chk("out_vld", out_vld_r, pend);
    if (pend) begin
      last_d = eq_d.pop_front();
      last_m = eq_m.pop_front();
      known  = 1;
    end
    if (known)
      chk("out_r", out_r, last_d);
    chk("out_mask", out_mask_r, last_m);
  endtask

  initial begin
    rst      = 1'b1;
    in_vld   = 1'b0;
    in_w     = '0;
    in_vld_w = '0;
    req_vld  = 1'b0;
    req_mask = '0;

    //        r iv n rv  m     ir rr occ
    tv[0]  = '{1, 0, 0, 1, 8'h00, 1, 1, 0};
    tv[1]  = '{1, 0, 0, 1, 8'h01, 1, 0, 0};
    tv[2]  = '{0, 0, 0, 1, 8'h00, 1, 1, 0};
    tv[3]  = '{0, 1, 3, 0, 8'h00, 1, 1, 3};
    tv[4]  = '{0, 0, 0, 1, 8'h85, 1, 1, 0};
    tv[5]  = '{0, 1, 5, 0, 8'h00, 1, 1, 5};
    tv[6]  = '{0, 0, 0, 1, 8'hFF, 1, 0, 5};
    tv[7]  = '{0, 1, 3, 1, 8'hFF, 1, 0, 8};
    tv[8]  = '{0, 0, 0, 1, 8'hFF, 1, 1, 0};
    tv[9]  = '{0, 1, 8, 0, 8'h00, 1, 1, 8};
    tv[10] = '{0, 1, 1, 0, 8'h00, 1, 1, 9};
    tv[11] = '{0, 1, 2, 0, 8'h00, 0, 1, 9};
    tv[12] = '{0, 0, 0, 1, 8'h01, 0, 1, 8};
    tv[13] = '{0, 1, 0, 0, 8'h00, 1, 1, 8};
    tv[14] = '{0, 0, 0, 1, 8'hFF, 1, 1, 0};
    tv[15] = '{0, 1, 4, 0, 8'h00, 1, 1, 4};
    tv[16] = '{0, 1, 8, 1, 8'h0F, 1, 1, 8};
    tv[17] = '{0, 0, 0, 1, 8'hFF, 1, 1, 0};
    tv[18] = '{0, 1, 6, 0, 8'h00, 1, 1, 6};
    tv[19] = '{0, 0, 0, 1, 8'h5A, 1, 1, 2};
    tv[20] = '{0, 1, 4, 0, 8'h00, 1, 1, 6};
    tv[21] = '{0, 0, 0, 1, 8'h00, 1, 1, 6};

    for (int k = 0; k < 22; k++)
      step(tv[k]);

    // Mid-operation reset with a request pending
    step('{1, 0, 0, 1, 8'h01, 1, 0, 0});
    step('{0, 0, 0, 1, 8'h01, 1, 0, 0});
    step('{0, 0, 0, 1, 8'h01, 1, 0, 0});
    step('{0, 1, 1, 1, 8'h01, 1, 0, 1});
    step('{0, 0, 0, 1, 8'h01, 1, 1, 0});
    step('{0, 0, 0, 0, 8'h00, 1, 1, 0});

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/unpack.md
UNPACK -- requirements
Module: unpack

Interface
REQ-001 Parameter N, default 8, number of lanes.
REQ-002 Parameter W, default 32, lane data width.
REQ-003 Clock is clk; reset is rst, synchronous, active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_vld  input  1  packed input beat present.
REQ-007 in_rdy  output  1  beat accepted when in_vld & in_rdy.
REQ-008 in_w  input  N x W  packed data, entry 0 oldest.
REQ-009 in_vld_w  input  N  unary entry mask (contiguous from lane 0), same format as the pack block's output valid.
REQ-010 req_vld  input  1  scatter request present.
REQ-011 req_rdy  output  1  request accepted when req_vld & req_rdy.
REQ-012 req_mask  input  N  destination lanes to fill.
REQ-013 out_vld_r  output  1  registered scatter result valid, single-cycle pulse.
REQ-014 out_r  output  N x W  registered scattered data.
REQ-015 out_mask_r  output  N  registered copy of accepted req_mask.

Function
REQ-016 Residue buffer holds up to 2N entries in FIFO order; occupancy occ_r, width $clog2(2N+1).
REQ-017 in_rdy = (occ_r <= N); combinational from occ_r only.
REQ-018 req_rdy = (occ_r >= popcnt(req_mask)); same-cycle input is not counted.
REQ-019 Accepted beat appends popcnt(in_vld_w) entries after all residue remaining after same-cycle consumption.
REQ-020 Accepted request consumes the popcnt(req_mask) oldest entries; remaining entries shift to the head, order preserved.
REQ-021 Scatter: lane i with req_mask[i]=1 gets consumed entry popcnt(req_mask[i-1:0]); lanes with req_mask[i]=0 output zero.
REQ-022 Latency: out_vld_r, out_r, out_mask_r valid the cycle after request acceptance; no output backpressure.
REQ-023 out_vld_r = 0 in any cycle following a cycle without request acceptance; out_r and out_mask_r hold their last values.
REQ-024 Simultaneous input and request: occ_r next = occ_r - popcnt(req_mask) + popcnt(in_vld_w).
REQ-025 req_mask = 0: always accepted, consumes nothing, out_vld_r pulses with out_mask_r = 0 and out_r = 0.
REQ-026 Accepted beat with in_vld_w = 0: no-op, occ_r unchanged.
REQ-027 Non-unary in_vld_w on an accepted beat is illegal; simulation assertion fires.
REQ-028 occ_r never exceeds 2N; an assertion checks this.

Reset
REQ-029 On rst: occ_r = 0, out_vld_r = 0, out_mask_r = 0; buffer and out_r data are not reset.
REQ-030 During reset and the cycle after it: in_rdy = 1; req_rdy = 1 only for req_mask = 0.
REQ-031 Reset mid-operation discards all residue; no partially consumed request is emitted.

Structure
REQ-032 popcnt and to_unary functions and the lane-index typedef are defined in the shared library package, for reuse by pack and unpack.
REQ-033 The combinational scatter crossbar (entries + mask -> lanes) is sub-module unpack_xbar; buffer and occupancy logic are in unpack.

Verification (N=8, W=32)
REQ-034 Reset; beat {A,B,C}, in_vld_w=0x07; next cycle req_mask=0x85 -> one cycle later out_vld_r=1, lane0=A, lane2=B, lane7=C, other lanes 0, out_mask_r=0x85, occ_r=0.
REQ-035 occ_r=5, req_mask=0xFF -> req_rdy=0; beat of 3 accepted -> next cycle req_rdy=1 -> out lanes 0..7 = the 8 entries in arrival order, occ_r=0.
REQ-036 Fill to occ_r=9 -> in_rdy=0; request 0x01 accepted -> occ_r=8, in_rdy=1.
REQ-037 occ_r=4 {P,Q,R,S}, same cycle req_mask=0x0F and beat of 8 {T0..T7} -> out lanes0-3 = P,Q,R,S; occ_r=8; next req 0xFF -> out = T0..T7.
REQ-038 occ_r=0, req_mask=0x00 -> accepted, next cycle out_vld_r=1, out_mask_r=0, out_r=0.
REQ-039 occ_r=6, assert rst one cycle -> out_vld_r=0, occ_r=0, in_rdy=1; req_mask=0x01 -> req_rdy=0 until a beat arrives.
